// File: rtl/scene_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scene_pkg
// Purpose  : Shared encodings and defaults for the VGA scene sequencer.
//            Holds scene and memory-bank encodings, image/screen geometry
//            defaults and the per-channel fade helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package scene_pkg;

  // Geometry defaults
  localparam int IMG_W_DEF    = 320;
  localparam int IMG_H_DEF    = 240;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Scene encodings (state register values)
  typedef logic [1:0] scene_t;
  localparam logic [1:0] SCENE_TITLE    = 2'd0;
  localparam logic [1:0] SCENE_FADE_OUT = 2'd1;
  localparam logic [1:0] SCENE_PLAY     = 2'd2;
  localparam logic [1:0] SCENE_OVER     = 2'd3;

  // Shared image-memory bank selects
  localparam logic [1:0] BANK_TITLE = 2'd0;
  localparam logic [1:0] BANK_GAME  = 2'd1;
  localparam logic [1:0] BANK_OVER  = 2'd2;

  // One colour channel scaled by level/16; level 16 returns c unchanged.
  function automatic logic [3:0] fade_nibble(input logic [3:0] c,
                                             input logic [4:0] level);
    logic [8:0] prod;
    prod = {5'd0, c} * {4'd0, level};
    return prod[7:4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fade.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fade
// Purpose  : Registered RGB444 brightness scaler with blanking. Forms the
//            last stage of the scene pixel pipeline.
// Ports    : clk, rst_n   - clock, async active-low reset
//            pix_in[11:0] - RGB444 pixel from image memory
//            level[4:0]   - brightness, 0..16 (16 = unchanged)
//            blank        - force output to black
//            pix_out[11:0]- registered scaled pixel
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fade
  import scene_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] pix_in,
  input  logic [4:0]  level,
  input  logic        blank,
  output logic [11:0] pix_out
);

  logic [11:0] pix_d;
  logic [11:0] pix_q;

  always_comb begin
    pix_d = 12'd0;
    if (!blank) begin
      pix_d = {fade_nibble(pix_in[11:8], level),
               fade_nibble(pix_in[7:4],  level),
               fade_nibble(pix_in[3:0],  level)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_q <= 12'd0;
    else        pix_q <= pix_d;
  end

  assign pix_out = pix_q;

endmodule
`default_nettype wire

// File: rtl/scene_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scene_ctrl
// Purpose  : Scene sequencer for the VGA game. Runs the TITLE / FADE_OUT /
//            PLAY / OVER state machine on frame boundaries, arbitrates the
//            shared image-memory read port and fades the pixel stream.
// Ports    : clk, rst_n        - clock, async active-low reset
//            h_cnt, v_cnt      - VGA counters
//            btn_start         - start pulse (TITLE / OVER)
//            game_over         - end-of-game pulse (PLAY)
//            game_mem_addr     - renderer address, used in PLAY
//            mem_data          - shared memory read data (1-clk latency)
//            mem_addr, mem_sel - registered memory address / bank select
//            vga_data          - registered RGB444 output
//            scene, game_run   - current scene, high in PLAY
// Revision : 1.0 - initial release
// ============================================================================
module scene_ctrl
  import scene_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int FADE_STEPS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        btn_start,
  input  logic        game_over,
  input  logic [16:0] game_mem_addr,
  input  logic [11:0] mem_data,
  output logic [16:0] mem_addr,
  output logic [1:0]  mem_sel,
  output logic [11:0] vga_data,
  output logic [1:0]  scene,
  output logic        game_run
);

  localparam logic [19:0] IMG_SIZE   = 20'(IMG_W * IMG_H);
  localparam logic [19:0] IMG_SIZE2  = 20'(2 * IMG_W * IMG_H);
  localparam logic [4:0]  LEVEL_FULL = 5'(FADE_STEPS);

  // --------------------------------------------------------------------------
  // Frame tick: first clk of v_cnt == V_ACTIVE
  // --------------------------------------------------------------------------
  logic [9:0] v_prev_d, v_prev_q;
  logic       frame_tick;

  assign v_prev_d   = v_cnt;
  assign frame_tick = (v_cnt == 10'(V_ACTIVE)) && (v_prev_q != 10'(V_ACTIVE));

  // --------------------------------------------------------------------------
  // Scene state machine
  // --------------------------------------------------------------------------
  scene_t     scene_d, scene_q;
  logic [4:0] level_d, level_q;
  logic       start_pend_d, start_pend_q;
  logic       over_pend_d, over_pend_q;

  always_comb begin
    scene_d      = scene_q;
    level_d      = level_q;
    start_pend_d = start_pend_q;
    over_pend_d  = over_pend_q;

    // Latch pulses; a pulse coincident with frame_tick is seen only by the
    // following tick because the transition below reads the _q flags.
    if (btn_start && (scene_q == SCENE_TITLE || scene_q == SCENE_OVER))
      start_pend_d = 1'b1;
    if (game_over && scene_q == SCENE_PLAY)
      over_pend_d = 1'b1;

    // Transition-time clears take priority over a same-clk pulse.
    if (frame_tick) begin
      case (scene_q)
        SCENE_TITLE: begin
          if (start_pend_q) begin
            scene_d      = SCENE_FADE_OUT;
            level_d      = LEVEL_FULL;
            start_pend_d = 1'b0;
          end
        end
        SCENE_FADE_OUT: begin
          if (level_q == 5'd0) begin
            scene_d = SCENE_PLAY;
            level_d = LEVEL_FULL;
          end else begin
            level_d = level_q - 5'd1;
          end
        end
        SCENE_PLAY: begin
          if (over_pend_q) begin
            scene_d     = SCENE_OVER;
            over_pend_d = 1'b0;
          end
        end
        default: begin // SCENE_OVER
          if (start_pend_q) begin
            scene_d      = SCENE_TITLE;
            start_pend_d = 1'b0;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Image address: (h/2) + IMG_W*(v/2), wrapped into the image. The raw sum
  // is below 3*IMG_W*IMG_H for 10-bit counters at the default geometry, so
  // two conditional subtractions replace a general modulo.
  // --------------------------------------------------------------------------
  logic [19:0] img_sum;
  logic [19:0] img_mod;

  always_comb begin
    img_sum = 20'(h_cnt[9:1]) + 20'(IMG_W) * 20'(v_cnt[9:1]);
    if (img_sum >= IMG_SIZE2)     img_mod = img_sum - IMG_SIZE2;
    else if (img_sum >= IMG_SIZE) img_mod = img_sum - IMG_SIZE;
    else                          img_mod = img_sum;
  end

  // --------------------------------------------------------------------------
  // Stage 1: port ownership follows scene_d so a scene change appears on
  // mem_addr one clk after frame_tick.
  // --------------------------------------------------------------------------
  logic [16:0] mem_addr_d, mem_addr_q;
  logic [1:0]  mem_sel_d, mem_sel_q;
  logic        vis_d, vis1_q, vis2_q;

  always_comb begin
    mem_addr_d = img_mod[16:0];
    mem_sel_d  = BANK_TITLE;
    case (scene_d)
      SCENE_PLAY: begin
        mem_addr_d = game_mem_addr;
        mem_sel_d  = BANK_GAME;
      end
      SCENE_OVER: mem_sel_d = BANK_OVER;
      default:    mem_sel_d = BANK_TITLE;
    endcase
  end

  assign vis_d = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_prev_q     <= 10'd0;
      scene_q      <= SCENE_TITLE;
      level_q      <= LEVEL_FULL;
      start_pend_q <= 1'b0;
      over_pend_q  <= 1'b0;
      mem_addr_q   <= 17'd0;
      mem_sel_q    <= BANK_TITLE;
      vis1_q       <= 1'b0;
      vis2_q       <= 1'b0;
    end else begin
      v_prev_q     <= v_prev_d;
      scene_q      <= scene_d;
      level_q      <= level_d;
      start_pend_q <= start_pend_d;
      over_pend_q  <= over_pend_d;
      mem_addr_q   <= mem_addr_d;
      mem_sel_q    <= mem_sel_d;
      vis1_q       <= vis_d;
      vis2_q       <= vis1_q;  // aligned with mem_data
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: fade and blanking
  // --------------------------------------------------------------------------
  pixel_fade u_pixel_fade (
    .clk     (clk),
    .rst_n   (rst_n),
    .pix_in  (mem_data),
    .level   (level_q),
    .blank   (!vis2_q),
    .pix_out (vga_data)
  );

  assign mem_addr = mem_addr_q;
  assign mem_sel  = mem_sel_q;
  assign scene    = scene_q;
  assign game_run = (scene_q == SCENE_PLAY);

endmodule
`default_nettype wire
